// File: rtl/glyph_plotter.sv
// Draws a glyph bitmap into a text-grid cell. Each cycle it emits one pixel on an
// (X, Y, COLOUR, PLOT) write port, and it waits on PIX_READY when a pixel is plotted.
`timescale 1ns/1ps
module glyph_plotter #(
    parameter int GLYPH_W     = 8,
    parameter int GLYPH_H     = 16,
    parameter int SCREEN_COLS = 20,
    parameter int SCREEN_ROWS = 7,
    parameter bit TRANSPARENT = 1'b0
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
    input  logic [127:0] GLYPH,
    input  logic [4:0]   COL,
    input  logic [2:0]   ROW,
    input  logic [2:0]   FG,
    input  logic [2:0]   BG,
    input  logic         PIX_READY,
    output logic [7:0]   X,
    output logic [6:0]   Y,
    output logic [2:0]   COLOUR,
    output logic         PLOT,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic [1:0]   dbg_state
);

    localparam int NBITS = GLYPH_W * GLYPH_H;
    localparam int PX_W  = $clog2(GLYPH_W);
    localparam int PY_W  = $clog2(GLYPH_H);
    localparam int IDX_W = PX_W + PY_W;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBITS - 1);
    localparam logic [PX_W-1:0]  PX_LAST = PX_W'(GLYPH_W - 1);
    localparam logic [PY_W-1:0]  PY_LAST = PY_W'(GLYPH_H - 1);

    // Handshake: a pixel is transferred on a rising edge where PLOT and PIX_READY are
    // both high. While PLOT is high and PIX_READY is low, X/Y/COLOUR/PLOT stay stable.
    // A transparent skip (PLOT low during DRAW) advances without waiting on PIX_READY.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  glyph_q, glyph_d;
    logic [4:0]        col_q, col_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        fg_q, fg_d;
    logic [2:0]        bg_q, bg_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [PY_W-1:0]   py_q, py_d;
    logic              err_q, err_d;

    logic              in_range;
    logic [IDX_W-1:0]  pix_idx;
    logic              pix_bit;
    logic              plot_raw;
    logic              consume;
    logic              last_pix;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            glyph_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            glyph_q <= glyph_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            px_q    <= px_d;
            py_q    <= py_d;
            err_q   <= err_d;
        end
    end

    // Bitmap row 0 sits in the MSBs and the leftmost pixel of a row is its MSB.
    // That makes the bit for pixel (px, py) glyph[NBITS-1 - (py*GLYPH_W + px)].
    always_comb begin
        in_range = (COL < 5'(SCREEN_COLS)) && (ROW < 3'(SCREEN_ROWS));
        pix_idx  = {py_q, px_q};
        pix_bit  = glyph_q[IDX_MAX - pix_idx];
        plot_raw = TRANSPARENT ? pix_bit : 1'b1;
        consume  = !plot_raw || PIX_READY;
        last_pix = (px_q == PX_LAST) && (py_q == PY_LAST);
    end

    always_comb begin
        state_d = state_q;
        glyph_d = glyph_q;
        col_d   = col_q;
        row_d   = row_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        px_d    = px_q;
        py_d    = py_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (in_range) begin
                        glyph_d = GLYPH;
                        col_d   = COL;
                        row_d   = ROW;
                        fg_d    = FG;
                        bg_d    = BG;
                        px_d    = '0;
                        py_d    = '0;
                        state_d = S_DRAW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if (consume) begin
                    if (last_pix) begin
                        state_d = S_FIN;
                    end else if (px_q == PX_LAST) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state, so an asynchronous reset clears them at once.
    always_comb begin
        X         = '0;
        Y         = '0;
        COLOUR    = '0;
        PLOT      = 1'b0;
        BUSY      = (state_q != S_IDLE);
        DONE      = (state_q == S_FIN);
        ERR       = err_q;
        dbg_state = state_q;
        if (state_q == S_DRAW) begin
            X      = {col_q, px_q};
            Y      = {row_q, py_q};
            COLOUR = pix_bit ? fg_q : bg_q;
            PLOT   = plot_raw;
        end
    end

endmodule

// File: tb/tb_glyph_plotter.sv
// Bench for glyph_plotter. A reference model fills a queue with the expected pixels,
// and a monitor pops one entry and compares it on each accepted PLOT.
`timescale 1ns/1ps
module tb_glyph_plotter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start1;
  logic [127:0] glyph, glyph1;
  logic [4:0]   col;
  logic [2:0]   row, fg, bg;
  logic         pix_ready, pix_ready1;

  logic [7:0] x, x1;
  logic [6:0] y, y1;
  logic [2:0] colour, colour1;
  logic       plot, busy, done, err;
  logic       plot1, busy1, done1, err1;
  logic [1:0] dbg, dbg1;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  glyph_plotter #(.TRANSPARENT(1'b0)) dut (
    .CLK(clk), .RESETN(rst_n), .START(start), .GLYPH(glyph), .COL(col), .ROW(row),
    .FG(fg), .BG(bg), .PIX_READY(pix_ready), .X(x), .Y(y), .COLOUR(colour),
    .PLOT(plot), .BUSY(busy), .DONE(done), .ERR(err), .dbg_state(dbg)
  );

  glyph_plotter #(.TRANSPARENT(1'b1)) dut_t (
    .CLK(clk), .RESETN(rst_n), .START(start1), .GLYPH(glyph1), .COL(col), .ROW(row),
    .FG(fg), .BG(bg), .PIX_READY(pix_ready1), .X(x1), .Y(y1), .COLOUR(colour1),
    .PLOT(plot1), .BUSY(busy1), .DONE(done1), .ERR(err1), .dbg_state(dbg1)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void push_expected(input logic [127:0] g, input logic [4:0] c,
                                        input logic [2:0] r, input logic [2:0] f, input logic [2:0] b);
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 8; px++) begin
        logic       bt;
        logic [7:0] ex;
        logic [6:0] ey;
        bt = g[127 - (py * 8 + px)];
        ex = 8'(int'(c) * 8 + px);
        ey = 7'(int'(r) * 16 + py);
        exp_q.push_back({ex, ey, bt ? f : b});
      end
    end
  endfunction

  function automatic logic [127:0] glyph_one();
    logic [7:0] rows [16];
    logic [127:0] g;
    rows = '{8'h00, 8'h10, 8'h30, 8'h50, 8'h10, 8'h10, 8'h10, 8'h10,
             8'h10, 8'h10, 8'h10, 8'h10, 8'h7C, 8'h00, 8'h00, 8'h00};
    g = '0;
    for (int i = 0; i < 16; i++) g[127 - 8 * i -: 8] = rows[i];
    return g;
  endfunction

  function automatic logic [127:0] rand_glyph();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out   = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) check("hold_stable", {x, y, colour, plot}, prev_out);
      prev_stall = rst_n && plot && !pix_ready;
      prev_out   = {x, y, colour, plot};
      if (rst_n && plot && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pixel: got x=%0d y=%0d c=%0d with empty queue", x, y, colour);
        end else begin
          check("pixel", {x, y, colour}, exp_q.pop_front());
        end
      end
      if (done) check("done_queue_empty", exp_q.size(), 0);
    end
  end

  // ---------------- drivers ----------------
  // mode: 0 ready held high, 1 stall on pixel 5, 2 random ready,
  //       3 second START at pixel 40, 4 reset at pixel 60
  task automatic do_draw(input logic [127:0] g, input logic [4:0] c, input logic [2:0] r,
                         input logic [2:0] f, input logic [2:0] b, input int mode,
                         output int done_cyc, output int plot_cyc);
    int  cyc;
    bit  aborted;
    push_expected(g, c, r, f, b);
    glyph = g; col = c; row = r; fg = f; bg = b; start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    glyph = rand_glyph(); col = 5'($urandom_range(0, 31)); row = 3'($urandom_range(0, 7));
    fg = 3'($urandom_range(0, 7)); bg = 3'($urandom_range(0, 7));
    cyc = 1; done_cyc = -1; plot_cyc = 0; aborted = 1'b0;
    check("busy_first_cycle", busy, 1);
    while (cyc < 1000) begin
      if (plot) plot_cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        1: pix_ready = !(cyc >= 6 && cyc <= 8);
        2: pix_ready = ($urandom_range(0, 2) != 0);
        3: begin
          start = (cyc == 41);
          if (cyc == 41) begin
            col = 5'((int'(c) + 7) % 20);
            row = 3'((int'(r) + 3) % 7);
          end
        end
        4: if (cyc == 61) begin
          rst_n = 1'b0;
          #1;
          check("rst_plot", plot, 0);
          check("rst_busy", busy, 0);
          check("rst_xy", {x, y}, 0);
          check("pixels_left_at_reset", exp_q.size(), 68);
          exp_q.delete();
          aborted = 1'b1;
        end
        default: ;
      endcase
      if (aborted) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      int d, p;
      @(posedge clk); #1;
      rst_n = 1'b1;
      d = 0; p = 0;
      repeat (140) begin
        @(posedge clk); #1;
        if (done) d++;
        if (plot) p++;
      end
      check("no_done_after_reset", d, 0);
      check("no_plot_after_reset", p, 0);
    end else if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE within %0d cycles", cyc);
      exp_q.delete();
    end else begin
      check("busy_on_done", busy, 1);
      @(posedge clk); #1;
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic err_case(input logic [4:0] c, input logic [2:0] r);
    int p;
    col = c; row = r; start = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    p = int'(plot);
    @(posedge clk); #1;
    check("err_one_cycle", err, 0);
    check("err_busy_after", busy, 0);
    p += int'(plot);
    check("err_no_plot", p, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, pc;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; pix_ready = 1'b0; pix_ready1 = 1'b0;
    glyph = '0; glyph1 = '0; col = '0; row = '0; fg = '0; bg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_xy", {x, y}, 0);
    check("reset_colour", colour, 0);
    check("reset_flags", {plot, busy, done, err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_draw(glyph_one(), 5'd2, 3'd1, 3'd7, 3'd0, 0, dc, pc);
    check("t1_done_cycle", dc, 129);
    check("t1_plot_cycles", pc, 128);

    do_draw(glyph_one(), 5'd2, 3'd1, 3'd7, 3'd0, 1, dc, pc);
    check("t2_done_cycle", dc, 132);
    check("t2_plot_cycles", pc, 131);

    err_case(5'd20, 3'd0);
    err_case(5'd0, 3'd7);
    err_case(5'd31, 3'd2);

    begin
      int cyc, plots, d1;
      col = 5'd3; row = 3'd2; glyph1 = '0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 1; plots = 0; d1 = -1;
      while (cyc < 400) begin
        if (plot1) plots++;
        if (done1) begin
          d1 = cyc;
          break;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check("t4_done_cycle", d1, 129);
      check("t4_plot_cycles", plots, 0);
    end

    do_draw(rand_glyph(), 5'd4, 3'd2, 3'd5, 3'd2, 3, dc, pc);
    check("t5_done_cycle", dc, 129);

    do_draw(rand_glyph(), 5'd9, 3'd5, 3'd3, 3'd4, 4, dc, pc);
    do_draw(rand_glyph(), 5'd0, 3'd0, 3'd6, 3'd1, 0, dc, pc);
    check("t6_redraw_done_cycle", dc, 129);

    do_draw('0, 5'd19, 3'd6, 3'd2, 3'd5, 0, dc, pc);
    check("blank_plot_cycles", pc, 128);

    repeat (4) begin
      do_draw(rand_glyph(), 5'($urandom_range(0, 19)), 3'($urandom_range(0, 6)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2, dc, pc);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
